spi_arbiter: RTL and testbench
==============================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 SETUP_CYC, default 2: clocks from ce assertion to the first byte start.
REQ-002 HOLD_CYC, default 2: clocks ce stays asserted after the last byte completes.
REQ-003 GAP_CYC, default 4: idle clocks with all ce low between transactions.
REQ-004 TIMEOUT, default 1024: clocks allowed from eng_start to eng_done.
REQ-005 clk  input  1  single clock; all logic on posedge clk.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req  input  2  level request per channel; bit i = channel i.
REQ-008 len0  input  3  channel 0 byte count; valid while req[0] high.
REQ-009 len1  input  3  channel 1 byte count; valid while req[1] high.
REQ-010 txd0  input  32  channel 0 tx bytes; the first byte sent is [31:24].
REQ-011 txd1  input  32  channel 1 tx bytes; the first byte sent is [31:24].
REQ-012 rxd0  output  32  channel 0 received bytes; the last byte is in [7:0].
REQ-013 rxd1  output  32  channel 1 received bytes; the last byte is in [7:0].
REQ-014 done  output  2  one-clock completion pulse per channel.
REQ-015 err  output  2  per-channel timeout flag; valid in the done cycle and held until that channel's next grant.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 ce  output  2  active-high device select per channel; at most one bit high.
REQ-018 eng_start  output  1  one-clock byte start pulse to the SPI byte engine.
REQ-019 eng_tx  output  8  byte to shift out; stable from eng_start until eng_done.
REQ-020 eng_busy  input  1  SPI byte engine busy.
REQ-021 eng_done  input  1  one-clock pulse; eng_rx is valid in the same cycle.
REQ-022 eng_rx  input  8  byte shifted in by the SPI byte engine.

Function
REQ-023 The block SHALL implement these states: IDLE, SETUP, LOAD, WAIT, HOLD, GAP.
REQ-024 IDLE: when req != 0, the block SHALL select a grant owner g, latch txd_g into the tx shift register, latch the clamped length, clear the rx shift register, set ce[g] at the next edge, and go to SETUP.
REQ-025 Arbitration SHALL be round-robin: if both req bits are high, the channel not last served wins; a single requester wins outright; last-served = 1 after reset, so channel 0 wins first.
REQ-026 Length clamping: len 5-7 SHALL be treated as 4; len 0 SHALL assert no ce, pulse done[g] one clock after grant, leave rxd_g unchanged, and go to GAP.
REQ-027 SETUP SHALL count SETUP_CYC clocks, then go to LOAD.
REQ-028 LOAD SHALL wait while eng_busy=1, then pulse eng_start with eng_tx = tx[31:24], start the timeout counter, and go to WAIT.
REQ-029 WAIT, on eng_done: rx <= {rx[23:0], eng_rx}, tx <= tx<<8, remaining count decrements; if bytes remain, go to LOAD, otherwise go to HOLD.
REQ-030 eng_done outside WAIT SHALL be ignored.
REQ-031 HOLD SHALL keep ce[g] high for HOLD_CYC clocks, then at one edge: ce<=0, rxd_g<=rx, done[g]=1; then go to GAP.
REQ-032 Timeout: if the timeout counter reaches TIMEOUT in WAIT, the block SHALL set ce<=0 and err[g]<=1, pulse done[g], leave rxd_g unchanged, and go to GAP.
REQ-033 GAP SHALL hold all ce low for GAP_CYC clocks, then go to IDLE; requests pending during a transaction wait and are never dropped.
REQ-034 A requester SHALL drop req in the cycle after done; if req is still high in IDLE, a new transaction starts.
REQ-035 Changes to req, lenX or txdX after grant SHALL have no effect on the transaction in progress.
REQ-036 Counters SHALL be sized from their parameters; no wrap-around within a state.

Reset
REQ-037 With reset high at a clock edge, the block SHALL enter IDLE and drive ce=0, eng_start=0, eng_tx=0, done=0, err=0, busy=0, rxd0=rxd1=0, last-served=1.
REQ-038 Reset mid-transaction SHALL abort the transaction with no done pulse, and ce SHALL be low after that edge.

Verification
REQ-039 req=01, len0=3, txd0=0x8001_0200, engine echoes eng_rx=0xA5,0x5A,0x3C -> three eng_start pulses with eng_tx 0x80,0x01,0x02; rxd0=0x00A55A3C; one done[0] pulse, coincident with ce[0] falling.
REQ-040 req=11 held through three transactions -> owners 0,1,0; ce never overlaps; at least GAP_CYC clocks with ce=00 between transactions.
REQ-041 len1=0 -> done[1] pulses with ce=00 throughout; len1=6 -> exactly 4 bytes sent.
REQ-042 Engine never asserts eng_done -> after TIMEOUT clocks: done[0] and err[0] high, ce=00, rxd0 unchanged.
REQ-043 Reset asserted in WAIT of byte 2 -> ce=00 and busy=0 at the next edge; no done pulse; the next request starts normally.
REQ-044 eng_busy held high for 10 clocks after SETUP -> eng_start is delayed until the clock after eng_busy falls.

Source files
------------

// File: rtl/spi_arbiter.sv
// Two-channel round-robin arbiter in front of a single SPI byte engine.
// Owns device selects, setup/hold/gap spacing and a per-byte timeout.
module spi_arbiter #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned HOLD_CYC  = 2,
  parameter int unsigned GAP_CYC   = 4,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [2:0]  len0,
  input  logic [2:0]  len1,
  input  logic [31:0] txd0,
  input  logic [31:0] txd1,
  output logic [31:0] rxd0,
  output logic [31:0] rxd1,
  output logic [1:0]  done,
  output logic [1:0]  err,
  output logic        busy,
  output logic [1:0]  ce,
  output logic        eng_start,
  output logic [7:0]  eng_tx,
  input  logic        eng_busy,
  input  logic        eng_done,
  input  logic [7:0]  eng_rx
);

  localparam int unsigned SH_MAX  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int unsigned CYC_MAX = (SH_MAX > GAP_CYC) ? SH_MAX : GAP_CYC;
  localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);
  localparam int unsigned TO_W    = $clog2(TIMEOUT + 1);
  localparam int unsigned LEN_W   = 3;
  localparam int unsigned MAX_LEN = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOAD,
    S_WAIT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t             state_q;
  logic               owner_q;
  logic               last_q;
  logic [31:0]        tx_q;
  logic [31:0]        rx_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [CYC_W-1:0]   cyc_q;
  logic [TO_W-1:0]    to_q;
  logic [1:0]         ce_q;
  logic [1:0]         done_q;
  logic [1:0]         err_q;
  logic               busy_q;
  logic               eng_start_q;
  logic [7:0]         eng_tx_q;
  logic [31:0]        rxd0_q;
  logic [31:0]        rxd1_q;

  logic               grant_c;
  logic [1:0]         grant_mask_c;
  logic [1:0]         owner_mask_c;
  logic [LEN_W-1:0]   len_raw_c;
  logic [LEN_W-1:0]   len_clamp_c;
  logic [31:0]        txd_sel_c;

  // Round-robin pick: on contention the channel not served last wins.
  always_comb begin
    grant_c      = (req == 2'b11) ? ~last_q : req[1];
    grant_mask_c = {grant_c, ~grant_c};
    owner_mask_c = {owner_q, ~owner_q};
    len_raw_c    = grant_c ? len1 : len0;
    len_clamp_c  = (len_raw_c > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_raw_c;
    txd_sel_c    = grant_c ? txd1 : txd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      tx_q        <= '0;
      rx_q        <= '0;
      cnt_q       <= '0;
      cyc_q       <= '0;
      to_q        <= '0;
      ce_q        <= '0;
      done_q      <= '0;
      err_q       <= '0;
      busy_q      <= 1'b0;
      eng_start_q <= 1'b0;
      eng_tx_q    <= '0;
      rxd0_q      <= '0;
      rxd1_q      <= '0;
    end else begin
      done_q      <= '0;
      eng_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req != 2'b00) begin
            owner_q <= grant_c;
            last_q  <= grant_c;
            err_q   <= err_q & ~grant_mask_c;
            busy_q  <= 1'b1;
            tx_q    <= txd_sel_c;
            rx_q    <= '0;
            cnt_q   <= len_clamp_c;
            cyc_q   <= '0;
            // Zero-length request completes immediately without touching the bus.
            if (len_clamp_c == '0) begin
              done_q  <= grant_mask_c;
              state_q <= S_GAP;
            end else begin
              ce_q    <= grant_mask_c;
              state_q <= S_SETUP;
            end
          end
        end

        S_SETUP: begin
          if (cyc_q == CYC_W'(SETUP_CYC - 1)) begin
            cyc_q   <= '0;
            state_q <= S_LOAD;
          end else begin
            cyc_q <= cyc_q + CYC_W'(1);
          end
        end

        S_LOAD: begin
          if (!eng_busy) begin
            eng_start_q <= 1'b1;
            eng_tx_q    <= tx_q[31:24];
            to_q        <= '0;
            state_q     <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (eng_done) begin
            rx_q  <= {rx_q[23:0], eng_rx};
            tx_q  <= {tx_q[23:0], 8'h00};
            cnt_q <= cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) begin
              cyc_q   <= '0;
              state_q <= S_HOLD;
            end else begin
              state_q <= S_LOAD;
            end
          end else if (to_q == TO_W'(TIMEOUT - 1)) begin
            ce_q    <= '0;
            err_q   <= err_q | owner_mask_c;
            done_q  <= owner_mask_c;
            cyc_q   <= '0;
            state_q <= S_GAP;
          end else begin
            to_q <= to_q + TO_W'(1);
          end
        end

        S_HOLD: begin
          if (cyc_q == CYC_W'(HOLD_CYC - 1)) begin
            ce_q   <= '0;
            done_q <= owner_mask_c;
            if (owner_q) begin
              rxd1_q <= rx_q;
            end else begin
              rxd0_q <= rx_q;
            end
            cyc_q   <= '0;
            state_q <= S_GAP;
          end else begin
            cyc_q <= cyc_q + CYC_W'(1);
          end
        end

        S_GAP: begin
          if (cyc_q == CYC_W'(GAP_CYC - 1)) begin
            cyc_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cyc_q <= cyc_q + CYC_W'(1);
          end
        end

        default: begin
          ce_q    <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rxd0      = rxd0_q;
  assign rxd1      = rxd1_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign ce        = ce_q;
  assign eng_start = eng_start_q;
  assign eng_tx    = eng_tx_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter: byte-engine model, tx/done/owner queues,
// one task per scenario.
module tb_spi_arbiter;

  localparam int unsigned SETUP_CYC = 2;
  localparam int unsigned HOLD_CYC  = 2;
  localparam int unsigned GAP_CYC   = 4;
  localparam int unsigned TIMEOUT   = 1024;
  localparam int unsigned ENG_LAT   = 3;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [2:0]  len0, len1;
  logic [31:0] txd0, txd1;
  logic [31:0] rxd0, rxd1;
  logic [1:0]  done, err, ce;
  logic        busy, eng_start;
  logic [7:0]  eng_tx;
  logic        eng_busy, eng_done;
  logic [7:0]  eng_rx;

  typedef struct packed {
    logic [1:0]  mask;
    logic [31:0] rxd;
    logic        err;
    logic [1:0]  prev_ce;
  } done_t;

  logic [7:0] exp_tx_q[$];
  done_t      exp_done_q[$];
  int         exp_owner_q[$];
  logic [7:0] eng_rx_q[$];

  int         checks, fails;
  int         start_cnt, done_cnt;
  logic [31:0] model_rxd0, model_rxd1;
  logic       eng_en, eng_pend;
  int         eng_wait;
  logic [1:0] ce_prev;
  bit         gap_armed;
  int         gap_len;

  spi_arbiter #(
    .SETUP_CYC(SETUP_CYC), .HOLD_CYC(HOLD_CYC), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .len0(len0), .len1(len1),
    .txd0(txd0), .txd1(txd1), .rxd0(rxd0), .rxd1(rxd1), .done(done),
    .err(err), .busy(busy), .ce(ce), .eng_start(eng_start), .eng_tx(eng_tx),
    .eng_busy(eng_busy), .eng_done(eng_done), .eng_rx(eng_rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle: observe DUT at the falling edge, then step the engine model.
  task automatic tick();
    done_t      d;
    logic [7:0] et;
    int         eo;
    @(negedge clk);
    if (reset) begin
      gap_armed = 0;
      ce_prev   = ce;
    end else begin
      checks++;
      if (ce === 2'b11) begin
        fails++; $display("FAIL ce_overlap: ce=%b required one-hot or zero", ce);
      end
      if (eng_start === 1'b1) begin
        start_cnt++;
        checks++;
        if (exp_tx_q.size() == 0) begin
          fails++; $display("FAIL unexpected_start: eng_tx=%h required no start", eng_tx);
        end else begin
          et = exp_tx_q.pop_front();
          if (eng_tx !== et) begin
            fails++; $display("FAIL eng_tx: got %h required %h", eng_tx, et);
          end
        end
      end
      if (done !== 2'b00) begin
        done_cnt++;
        checks++;
        if (exp_done_q.size() == 0) begin
          fails++; $display("FAIL unexpected_done: done=%b required 00", done);
        end else begin
          d = exp_done_q.pop_front();
          if (done !== d.mask || ((d.mask[1] ? rxd1 : rxd0) !== d.rxd) ||
              ((err & d.mask) !== (d.err ? d.mask : 2'b00)) || ce !== 2'b00 ||
              ce_prev !== d.prev_ce) begin
            fails++;
            $display("FAIL done_event: done=%b rxd0=%h rxd1=%h err=%b ce=%b prev_ce=%b required done=%b rxd=%h err=%b ce=00 prev_ce=%b",
                     done, rxd0, rxd1, err, ce, ce_prev, d.mask, d.rxd, d.err, d.prev_ce);
          end
        end
      end
      if (ce_prev == 2'b00 && ce != 2'b00) begin
        checks++;
        if (exp_owner_q.size() == 0) begin
          fails++; $display("FAIL unexpected_grant: ce=%b required 00", ce);
        end else begin
          eo = exp_owner_q.pop_front();
          if (ce !== (eo == 1 ? 2'b10 : 2'b01)) begin
            fails++; $display("FAIL owner: ce=%b required owner %0d", ce, eo);
          end
        end
        if (gap_armed) begin
          checks++;
          if (gap_len < int'(GAP_CYC)) begin
            fails++; $display("FAIL ce_gap: %0d idle clocks required >= %0d", gap_len, GAP_CYC);
          end
        end
        gap_armed = 0;
      end
      if (ce_prev != 2'b00 && ce == 2'b00) begin
        gap_armed = 1;
        gap_len   = 0;
      end
      if (ce == 2'b00 && gap_armed) gap_len++;
      ce_prev = ce;
    end
    // Engine model: answers each start with one eng_done pulse ENG_LAT cycles later.
    eng_done = 1'b0;
    if (reset) begin
      eng_pend = 1'b0;
      eng_rx_q.delete();
    end else begin
      if (eng_pend) begin
        if (eng_wait == 0) begin
          eng_done = 1'b1;
          eng_rx   = (eng_rx_q.size() != 0) ? eng_rx_q.pop_front() : 8'h00;
          eng_pend = 1'b0;
        end else begin
          eng_wait--;
        end
      end
      if (eng_start === 1'b1 && eng_en) begin
        eng_pend = 1'b1;
        eng_wait = int'(ENG_LAT) - 1;
      end
    end
  endtask

  task automatic push_done(input logic [1:0] m, input logic [31:0] r, input logic e,
                           input logic [1:0] p);
    done_t d;
    d.mask = m; d.rxd = r; d.err = e; d.prev_ce = p;
    exp_done_q.push_back(d);
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    for (int i = 0; i < budget && done_cnt < target; i++) tick();
    ok = (done_cnt >= target);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    for (int i = 0; i < budget && busy !== 1'b0; i++) tick();
    ok = (busy === 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 2'b00;
    repeat (2) tick();
    reset = 1'b0;
    model_rxd0 = '0; model_rxd1 = '0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 2'b00; len0 = '0; len1 = '0; txd0 = '0; txd1 = '0;
    eng_busy = 1'b0; eng_en = 1'b1;
    repeat (3) tick();
    checks++; if (ce !== 2'b00) begin fails++; $display("FAIL rst_ce: got %b required 00", ce); end
    checks++; if (eng_start !== 1'b0) begin fails++; $display("FAIL rst_eng_start: got %b required 0", eng_start); end
    checks++; if (eng_tx !== 8'h00) begin fails++; $display("FAIL rst_eng_tx: got %h required 00", eng_tx); end
    checks++; if (done !== 2'b00) begin fails++; $display("FAIL rst_done: got %b required 00", done); end
    checks++; if (err !== 2'b00) begin fails++; $display("FAIL rst_err: got %b required 00", err); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b required 0", busy); end
    checks++; if (rxd0 !== 32'h0) begin fails++; $display("FAIL rst_rxd0: got %h required 0", rxd0); end
    checks++; if (rxd1 !== 32'h0) begin fails++; $display("FAIL rst_rxd1: got %h required 0", rxd1); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int s0, d0; bit ok;
    len0 = 3'd3; txd0 = 32'h8001_0200;
    exp_tx_q.push_back(8'h80); exp_tx_q.push_back(8'h01); exp_tx_q.push_back(8'h02);
    eng_rx_q.push_back(8'hA5); eng_rx_q.push_back(8'h5A); eng_rx_q.push_back(8'h3C);
    exp_owner_q.push_back(0);
    model_rxd0 = 32'h00A5_5A3C;
    push_done(2'b01, model_rxd0, 1'b0, 2'b01);
    s0 = start_cnt; d0 = done_cnt;
    req = 2'b01;
    tick();
    checks++; if (ce !== 2'b01 || busy !== 1'b1) begin
      fails++; $display("FAIL basic_grant: ce=%b busy=%b required ce=01 busy=1", ce, busy);
    end
    wait_done(d0 + 1, 200, ok);
    req = 2'b00;
    checks++; if (!ok) begin fails++; $display("FAIL basic_timeout: done_cnt=%0d required %0d", done_cnt, d0 + 1); end
    wait_idle(50, ok);
    checks++; if (start_cnt - s0 !== 3) begin fails++; $display("FAIL basic_starts: got %0d required 3", start_cnt - s0); end
    checks++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL basic_done_count: got %0d required 1", done_cnt - d0); end
    checks++; if (rxd0 !== 32'h00A5_5A3C) begin fails++; $display("FAIL basic_rxd0: got %h required 00a55a3c", rxd0); end
    checks++; if (rxd1 !== model_rxd1) begin fails++; $display("FAIL basic_rxd1: got %h required %h", rxd1, model_rxd1); end
  endtask

  task automatic test_round_robin();
    int d0; bit ok;
    do_reset();
    len0 = 3'd1; len1 = 3'd1; txd0 = 32'h1100_0000; txd1 = 32'h2200_0000;
    exp_tx_q.push_back(8'h11); exp_tx_q.push_back(8'h22); exp_tx_q.push_back(8'h11);
    eng_rx_q.push_back(8'hB0); eng_rx_q.push_back(8'hB1); eng_rx_q.push_back(8'hB2);
    exp_owner_q.push_back(0); exp_owner_q.push_back(1); exp_owner_q.push_back(0);
    push_done(2'b01, 32'h0000_00B0, 1'b0, 2'b01);
    push_done(2'b10, 32'h0000_00B1, 1'b0, 2'b10);
    push_done(2'b01, 32'h0000_00B2, 1'b0, 2'b01);
    model_rxd0 = 32'h0000_00B2; model_rxd1 = 32'h0000_00B1;
    d0 = done_cnt;
    req = 2'b11;
    wait_done(d0 + 3, 400, ok);
    req = 2'b00;
    checks++; if (!ok) begin fails++; $display("FAIL rr_timeout: done_cnt=%0d required %0d", done_cnt, d0 + 3); end
    wait_idle(50, ok);
    checks++; if (done_cnt - d0 !== 3) begin fails++; $display("FAIL rr_done_count: got %0d required 3", done_cnt - d0); end
    checks++; if (rxd0 !== model_rxd0 || rxd1 !== model_rxd1) begin
      fails++; $display("FAIL rr_rxd: rxd0=%h rxd1=%h required %h %h", rxd0, rxd1, model_rxd0, model_rxd1);
    end
  endtask

  task automatic test_len_edges();
    int s0, d0; bit ok, ce_seen;
    len1 = 3'd0; txd1 = 32'hFFFF_FFFF;
    push_done(2'b10, model_rxd1, 1'b0, 2'b00);
    s0 = start_cnt;
    req = 2'b10;
    tick();
    checks++; if (done !== 2'b10 || ce !== 2'b00) begin
      fails++; $display("FAIL len0_done: done=%b ce=%b required done=10 ce=00", done, ce);
    end
    req = 2'b00;
    ce_seen = 0;
    for (int i = 0; i < 20 && busy !== 1'b0; i++) begin
      tick();
      if (ce !== 2'b00) ce_seen = 1;
    end
    checks++; if (ce_seen || start_cnt != s0) begin
      fails++; $display("FAIL len0_bus: ce_seen=%0d starts=%0d required 0 0", ce_seen, start_cnt - s0);
    end
    checks++; if (rxd1 !== model_rxd1) begin fails++; $display("FAIL len0_rxd1: got %h required %h", rxd1, model_rxd1); end
    len1 = 3'd6; txd1 = 32'hDEAD_BEEF;
    exp_tx_q.push_back(8'hDE); exp_tx_q.push_back(8'hAD); exp_tx_q.push_back(8'hBE); exp_tx_q.push_back(8'hEF);
    eng_rx_q.push_back(8'h01); eng_rx_q.push_back(8'h02); eng_rx_q.push_back(8'h03); eng_rx_q.push_back(8'h04);
    exp_owner_q.push_back(1);
    model_rxd1 = 32'h0102_0304;
    push_done(2'b10, model_rxd1, 1'b0, 2'b10);
    s0 = start_cnt; d0 = done_cnt;
    req = 2'b10;
    wait_done(d0 + 1, 300, ok);
    req = 2'b00;
    checks++; if (!ok) begin fails++; $display("FAIL len6_timeout: done_cnt=%0d required %0d", done_cnt, d0 + 1); end
    wait_idle(50, ok);
    checks++; if (start_cnt - s0 !== 4) begin fails++; $display("FAIL len6_starts: got %0d required 4", start_cnt - s0); end
    checks++; if (rxd1 !== model_rxd1) begin fails++; $display("FAIL len6_rxd1: got %h required %h", rxd1, model_rxd1); end
  endtask

  task automatic test_timeout();
    int d0, n; bit ok;
    eng_en = 1'b0;
    len0 = 3'd2; txd0 = 32'h1234_5678;
    exp_tx_q.push_back(8'h12);
    exp_owner_q.push_back(0);
    push_done(2'b01, model_rxd0, 1'b1, 2'b01);
    d0 = done_cnt; n = 0;
    req = 2'b01;
    while (done_cnt == d0 && n < int'(TIMEOUT) + 100) begin tick(); n++; end
    req = 2'b00;
    checks++; if (done_cnt != d0 + 1) begin fails++; $display("FAIL to_no_done: done_cnt=%0d required %0d", done_cnt, d0 + 1); end
    checks++; if (n < int'(TIMEOUT) || n > int'(TIMEOUT + SETUP_CYC) + 4) begin
      fails++; $display("FAIL to_latency: %0d clocks required %0d..%0d", n, TIMEOUT, TIMEOUT + SETUP_CYC + 4);
    end
    repeat (3) tick();
    checks++; if (err !== 2'b01) begin fails++; $display("FAIL to_err_hold: got %b required 01", err); end
    checks++; if (rxd0 !== model_rxd0) begin fails++; $display("FAIL to_rxd0: got %h required %h", rxd0, model_rxd0); end
    wait_idle(50, ok);
    eng_en = 1'b1;
  endtask

  task automatic test_eng_busy();
    int d0; bit ok, early;
    eng_busy = 1'b1;
    len0 = 3'd1; txd0 = 32'h5A00_0000;
    exp_tx_q.push_back(8'h5A); eng_rx_q.push_back(8'hC3);
    exp_owner_q.push_back(0);
    model_rxd0 = 32'h0000_00C3;
    push_done(2'b01, model_rxd0, 1'b0, 2'b01);
    d0 = done_cnt;
    req = 2'b01;
    tick();
    checks++; if (ce !== 2'b01 || err !== 2'b00) begin
      fails++; $display("FAIL busy_grant: ce=%b err=%b required ce=01 err=00", ce, err);
    end
    early = 0;
    repeat (SETUP_CYC + 10) begin
      tick();
      if (eng_start !== 1'b0) early = 1;
    end
    checks++; if (early) begin fails++; $display("FAIL busy_early_start: got start while eng_busy required none"); end
    eng_busy = 1'b0;
    tick();
    checks++; if (eng_start !== 1'b1) begin fails++; $display("FAIL busy_release_start: got %b required 1", eng_start); end
    wait_done(d0 + 1, 100, ok);
    req = 2'b00;
    checks++; if (!ok) begin fails++; $display("FAIL busy_timeout: done_cnt=%0d required %0d", done_cnt, d0 + 1); end
    wait_idle(50, ok);
    checks++; if (rxd0 !== model_rxd0) begin fails++; $display("FAIL busy_rxd0: got %h required %h", rxd0, model_rxd0); end
  endtask

  task automatic test_reset_mid();
    int s0, d0; bit ok;
    len0 = 3'd3; txd0 = 32'hA1B2_C3D4;
    exp_tx_q.push_back(8'hA1); exp_tx_q.push_back(8'hB2);
    eng_rx_q.push_back(8'h11);
    exp_owner_q.push_back(0);
    s0 = start_cnt;
    req = 2'b01;
    for (int i = 0; i < 100 && start_cnt < s0 + 2; i++) tick();
    checks++; if (start_cnt != s0 + 2) begin fails++; $display("FAIL mid_no_second_byte: starts=%0d required 2", start_cnt - s0); end
    reset = 1'b1; req = 2'b00;
    tick();
    checks++; if (ce !== 2'b00 || busy !== 1'b0 || done !== 2'b00) begin
      fails++; $display("FAIL mid_reset: ce=%b busy=%b done=%b required 00 0 00", ce, busy, done);
    end
    tick();
    reset = 1'b0;
    model_rxd0 = '0; model_rxd1 = '0;
    d0 = done_cnt;
    repeat (10) tick();
    checks++; if (done_cnt != d0 || rxd0 !== 32'h0) begin
      fails++; $display("FAIL mid_aftermath: dones=%0d rxd0=%h required 0 0", done_cnt - d0, rxd0);
    end
    len0 = 3'd1; txd0 = 32'h7700_0000;
    exp_tx_q.push_back(8'h77); eng_rx_q.push_back(8'h99);
    exp_owner_q.push_back(0);
    model_rxd0 = 32'h0000_0099;
    push_done(2'b01, model_rxd0, 1'b0, 2'b01);
    req = 2'b01;
    wait_done(d0 + 1, 100, ok);
    req = 2'b00;
    checks++; if (!ok) begin fails++; $display("FAIL mid_restart: done_cnt=%0d required %0d", done_cnt, d0 + 1); end
    wait_idle(50, ok);
    checks++; if (rxd0 !== model_rxd0) begin fails++; $display("FAIL mid_restart_rxd0: got %h required %h", rxd0, model_rxd0); end
  endtask

  initial begin
    checks = 0; fails = 0; start_cnt = 0; done_cnt = 0;
    model_rxd0 = '0; model_rxd1 = '0;
    eng_en = 1'b1; eng_pend = 1'b0; eng_wait = 0; eng_done = 1'b0; eng_rx = 8'h00;
    eng_busy = 1'b0; ce_prev = 2'b00; gap_armed = 0; gap_len = 0;
    reset = 1'b1; req = 2'b00; len0 = '0; len1 = '0; txd0 = '0; txd1 = '0;
    test_reset();
    test_basic();
    test_round_robin();
    test_len_edges();
    test_timeout();
    test_eng_busy();
    test_reset_mid();
    checks++;
    if (exp_tx_q.size() != 0 || exp_done_q.size() != 0 || exp_owner_q.size() != 0) begin
      fails++;
      $display("FAIL leftover_expectations: tx=%0d done=%0d owner=%0d required 0 0 0",
               exp_tx_q.size(), exp_done_q.size(), exp_owner_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
